mavg_filt_ctrl: RTL and testbench

Sequencer for the 8-bit moving-average filter in the PAM receive path. It runs the filter datapath through its phases:
- feeds samples into the filter every clock;
- suppresses output until the window holds N valid samples plus pipeline latency;
- decimates filter output to one symbol sample per symbol period;
- flushes the window with zeros on stop.

It sits between the ADC/sample source and the PAM slicer.

---
 rtl/pam_pkg.sv | 19 +
 rtl/sym_decim_cnt.sv | 32 +++
 rtl/mavg_filt_ctrl.sv | 134 +++++++++++++
 tb/tb_mavg_filt_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pam_pkg.sv
// pam_pkg: shared types and default parameters for the PAM receive path.
// Holds the controller state encoding, the sample width and the default
// filter and decimation parameters.
package pam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_e;

    localparam int SAMPLE_W      = 8;
    localparam int N_DEF         = 64;
    localparam int FILT_LAT_DEF  = 2;
    localparam int SPS_DEF       = 16;
    localparam int SYM_PHASE_DEF = 8;

endpackage

// File: rtl/sym_decim_cnt.sv
// sym_decim_cnt: symbol phase counter that wraps at SPS and strobes at SYM_PHASE.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   en_i      - advance the phase this clock
//   clr_i     - synchronous clear of the phase to 0 (wins over en_i)
//   strobe_o  - high in the clock whose edge takes a symbol (phase == SYM_PHASE)
module sym_decim_cnt #(
    parameter int SPS       = 16,
    parameter int SYM_PHASE = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic strobe_o
);

    localparam int PW = (SPS > 1) ? $clog2(SPS) : 1;

    logic [PW-1:0] phase_q, phase_d;

    assign phase_d  = clr_i ? '0 :
                      !en_i ? phase_q :
                      (phase_q == PW'(SPS - 1)) ? '0 : phase_q + 1'b1;
    assign strobe_o = en_i && !clr_i && (phase_q == PW'(SYM_PHASE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= '0;
        else     phase_q <= phase_d;
    end

endmodule

// File: rtl/mavg_filt_ctrl.sv
// mavg_filt_ctrl: sequencer for the moving-average filter in the PAM receive path.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start, stop  - begin acquisition / end acquisition and flush the filter
//   in_valid     - source sample strobe, in_data - signed source sample
//   filt_in      - registered sample to the filter, filt_result - filter output
//   sym_valid    - one-cycle strobe with sym_data, the decimated filter output
//   busy         - state is FILL, RUN or FLUSH
//   done         - one-cycle pulse on FLUSH -> IDLE
//   underrun     - sticky, in_valid was low while feeding the filter
module mavg_filt_ctrl
    import pam_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int FILT_LAT  = FILT_LAT_DEF,
    parameter int SPS       = SPS_DEF,
    parameter int SYM_PHASE = SYM_PHASE_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic [SAMPLE_W-1:0] filt_in,
    input  logic [SAMPLE_W-1:0] filt_result,
    output logic                sym_valid,
    output logic [SAMPLE_W-1:0] sym_data,
    output logic                busy,
    output logic                done,
    output logic                underrun
);

    localparam int                CNT_W    = $clog2(N + FILT_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N + FILT_LAT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] filt_in_q, filt_in_d;
    logic [SAMPLE_W-1:0] sym_data_q, sym_data_d;
    logic                sym_valid_q, sym_valid_d;
    logic                done_q, done_d;
    logic                underrun_q, underrun_d;
    logic                busy_q;
    logic                sym_strobe;

    // Phase is held at 0 outside RUN, so RUN always starts at phase 0.
    sym_decim_cnt #(
        .SPS       (SPS),
        .SYM_PHASE (SYM_PHASE)
    ) u_decim (
        .clk      (clk),
        .rst      (rst),
        .en_i     (state_q == RUN),
        .clr_i    (state_q != RUN),
        .strobe_o (sym_strobe)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        filt_in_d   = filt_in_q;
        sym_valid_d = 1'b0;
        sym_data_d  = sym_data_q;
        done_d      = 1'b0;
        underrun_d  = underrun_q;
        unique case (state_q)
            IDLE: begin
                filt_in_d = '0;
                if (start) begin
                    state_d    = FILL;
                    cnt_d      = '0;
                    underrun_d = 1'b0;
                end
            end
            FILL, RUN: begin
                if (in_valid) filt_in_d = in_data;
                else          underrun_d = 1'b1;
                // stop beats start and also beats a coincident symbol strobe;
                // zero feeding starts on this very edge.
                if (stop) begin
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    filt_in_d = '0;
                end else if (state_q == FILL) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = RUN;
                end else begin
                    sym_valid_d = sym_strobe;
                    if (sym_strobe) sym_data_d = filt_result;
                end
            end
            FLUSH: begin
                filt_in_d = '0;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            filt_in_q   <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            filt_in_q   <= filt_in_d;
            sym_valid_q <= sym_valid_d;
            sym_data_q  <= sym_data_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    assign filt_in   = filt_in_q;
    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_mavg_filt_ctrl.sv
// tb_mavg_filt_ctrl: directed self-checking bench for mavg_filt_ctrl.
module tb_mavg_filt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, in_valid = 1'b0;
    logic [7:0] in_data = 8'h00, filt_result = 8'h00;
    logic [7:0] filt_in, sym_data;
    logic       sym_valid, busy, done, underrun;

    int         checks = 0, failures = 0;
    logic [7:0] exp_sd = 8'h00;
    int         pulses;

    mavg_filt_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .filt_in     (filt_in),
        .filt_result (filt_result),
        .sym_valid   (sym_valid),
        .sym_data    (sym_data),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       start, stop, in_valid;
        logic [7:0] in_data;
        logic [7:0] fi;
        logic       sv;
        logic [7:0] sd;
        logic       busy, done, ur;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string nm, input logic [7:0] fi, input logic sv,
                           input logic [7:0] sd, input logic b, input logic d, input logic ur);
        chk({nm, ".filt_in"}, filt_in, fi);
        chk({nm, ".sym_valid"}, sym_valid, sv);
        chk({nm, ".sym_data"}, sym_data, sd);
        chk({nm, ".busy"}, busy, b);
        chk({nm, ".done"}, done, d);
        chk({nm, ".underrun"}, underrun, ur);
    endtask

    // Start, then FILL + run_edges RUN edges. Edge e counts from the start edge (e=0).
    // mode 0: in_data 0x20 (0x10 just before ur_edge), filt_result 0x20.
    // mode 1: in_data alternating 0x40/0xC0, filt_result a varying pattern.
    task automatic run_check(input int mode, input int run_edges, input int ur_edge,
                             output int np);
        logic [7:0] efi;
        logic       eur, esv;
        int         last;
        efi  = 8'h00;
        eur  = 1'b0;
        np   = 0;
        last = -1;
        start = 1'b1; in_valid = 1'b1; in_data = 8'h20;
        tick();
        start = 1'b0;
        chk("start.busy", busy, 1);
        chk("start.underrun", underrun, 0);
        chk("start.filt_in", filt_in, 0);
        for (int e = 1; e <= 66 + run_edges; e++) begin
            in_valid    = (e != ur_edge);
            in_data     = mode != 0 ? (e % 2 != 0 ? 8'hC0 : 8'h40) :
                          (e == ur_edge - 1) ? 8'h10 : (e == ur_edge) ? 8'h99 : 8'h20;
            filt_result = mode != 0 ? 8'((e * 37 + 5) % 256) : 8'h20;
            esv = (e >= 75) && ((e - 75) % 16 == 0);
            if (in_valid) efi = in_data;
            else          eur = 1'b1;
            if (esv) exp_sd = filt_result;
            tick();
            chk_all($sformatf("run@%0d", e), efi, esv, exp_sd, 1'b1, 1'b0, eur);
            if (sym_valid) begin
                np++;
                if (last >= 0) chk($sformatf("gap@%0d", e), e - last, 16);
                last = e;
            end
        end
    endtask

    // One-clock stop, then FLUSH with start pulses that must be ignored.
    task automatic stop_flush(input logic ur);
        stop = 1'b1; in_valid = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("stop", 8'h00, 1'b0, exp_sd, 1'b1, 1'b0, ur);
        for (int i = 1; i <= 66; i++) begin
            start   = (i == 10 || i == 40);
            in_data = 8'h7F;
            tick();
            start = 1'b0;
            chk_all($sformatf("flush@%0d", i), 8'h00, 1'b0, exp_sd, i < 66, i == 66, ur);
        end
        tick();
        chk_all("post_flush", 8'h00, 1'b0, exp_sd, 1'b0, 1'b0, ur);
    endtask

    initial begin
        // start,stop,valid,data -> filt_in,sym_valid,sym_data,busy,done,underrun
        tbl[0] = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h22, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 8'h33, 8'h22, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h44, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h55, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 8'h66, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};

        #2;
        chk_all("reset", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all("idle", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // IDLE stop, start+stop in IDLE and FILL, underrun in FILL, start in FLUSH.
        foreach (tbl[i]) begin
            start = tbl[i].start; stop = tbl[i].stop;
            in_valid = tbl[i].in_valid; in_data = tbl[i].in_data;
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].fi, tbl[i].sv, tbl[i].sd,
                    tbl[i].busy, tbl[i].done, tbl[i].ur);
        end
        start = 1'b0; stop = 1'b0;
        for (int i = 3; i <= 66; i++) begin
            tick();
            chk($sformatf("tflush%0d.done", i), done, i == 66);
            chk($sformatf("tflush%0d.busy", i), busy, i < 66);
        end
        tick();
        chk_all("tbl_end", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Nominal timing with one underrun clock in RUN, then stop/flush.
        run_check(0, 50, 80, pulses);
        chk("nominal.pulses", pulses, 3);
        stop_flush(1'b1);

        // Async reset mid-RUN, between edges.
        start = 1'b1; in_valid = 1'b1; in_data = 8'h20; filt_result = 8'h20;
        tick();
        start = 1'b0;
        repeat (100) tick();
        chk("pre_rst.sym_data", sym_data, 8'h20);
        chk("pre_rst.filt_in", filt_in, 8'h20);
        #3;
        rst = 1'b1;
        #1;
        exp_sd = 8'h00;
        chk_all("async_rst", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rst_hold.done", done, 0);
        rst = 1'b0;
        tick();
        chk_all("rst_rel", 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        run_check(0, 50, 0, pulses);
        chk("after_rst.pulses", pulses, 3);
        stop_flush(1'b0);

        // Long RUN: 1009 RUN clocks give strobes at RUN cycles 8, 24, ..., 1000.
        run_check(1, 1009, 0, pulses);
        chk("long.pulses", pulses, 63);
        stop_flush(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
